// File: rtl/booth_radix4_seq_if.sv
// Operand/result handshake bundle for booth_radix4_seq.
// Optional macro BOOTH_UNSIGNED_EN adds the op_signed operand-side signal.
// Both sides use valid/ready: a transfer happens on a rising clk edge where
// valid and ready are both high; valid, once raised, holds its payload stable
// until that edge; ready never depends combinationally on valid.
interface booth_radix4_seq_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
`ifdef BOOTH_UNSIGNED_EN
    logic                 op_signed;
`endif
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;

    // Producer of operands and consumer of products.
    modport master (
        output in_valid,
        output multiplicand,
        output multiplier,
`ifdef BOOTH_UNSIGNED_EN
        output op_signed,
`endif
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  product
    );

    // The multiplier itself.
    modport slave (
        input  in_valid,
        input  multiplicand,
        input  multiplier,
`ifdef BOOTH_UNSIGNED_EN
        input  op_signed,
`endif
        input  out_ready,
        output in_ready,
        output out_valid,
        output product
    );
endinterface

// File: rtl/booth_radix4_seq.sv
// Iterative radix-4 Booth multiplier: one Booth digit per clock, full
// 2*WIDTH product held under back-pressure.
// Optional macro BOOTH_UNSIGNED_EN: adds op_signed and one extra digit so
// unsigned operands are exact too; otherwise operands are always signed.
module booth_radix4_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    booth_radix4_seq_if.slave    bus,
    output logic [1:0]           dbg_state
);

    if (((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_bad_width
        $error("booth_radix4_seq: WIDTH must be even and >= 4");
    end

`ifdef BOOTH_UNSIGNED_EN
    localparam int N  = WIDTH / 2 + 1;
    localparam int AW = WIDTH + 2;
`else
    localparam int N  = WIDTH / 2;
    localparam int AW = WIDTH;
`endif
    // Accumulator layout: {upper WIDTH+2 partial-sum bits, A_ext, Booth guard bit}
    localparam int ACC_W = (WIDTH + 2) + AW + 1;
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state, state_next;
    logic [ACC_W-1:0]     acc;
    logic [WIDTH+1:0]     m_ext;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   product_r;

    logic                 accept;
    logic                 finish;
    logic [WIDTH+1:0]     m_load;
    logic [AW-1:0]        a_load;
    logic [WIDTH+1:0]     addend;
    logic [WIDTH+1:0]     sum_upper;
    logic [ACC_W-1:0]     acc_sum;
    logic [ACC_W-1:0]     acc_step;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.product   = product_r;
    assign dbg_state     = state;

    // Operand extension for the load: sign- or zero-extend per operation type.
`ifdef BOOTH_UNSIGNED_EN
    assign m_load = bus.op_signed ? {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand}
                                  : {2'b00, bus.multiplicand};
    assign a_load = bus.op_signed ? {{2{bus.multiplier[WIDTH-1]}}, bus.multiplier}
                                  : {2'b00, bus.multiplier};
`else
    assign m_load = {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
    assign a_load = bus.multiplier;
`endif

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state decode and accept/finish strobes.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (cnt == CNT_W'(N - 1)) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // One Booth step: select the digit's addend, add into the upper field, shift by 2.
    always_comb begin
        addend = '0;
        case (acc[2:0])
            3'b001, 3'b010: addend = m_ext;
            3'b011:         addend = {m_ext[WIDTH:0], 1'b0};
            3'b100:         addend = '0 - {m_ext[WIDTH:0], 1'b0};
            3'b101, 3'b110: addend = '0 - m_ext;
            default:        addend = '0;
        endcase
        sum_upper = acc[ACC_W-1 -: (WIDTH + 2)] + addend;
        acc_sum   = {sum_upper, acc[AW:0]};
        acc_step  = {{2{acc_sum[ACC_W-1]}}, acc_sum[ACC_W-1:2]};
    end

    // Datapath registers: load on accept, step in CALC, capture product on the last step.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc       <= '0;
            m_ext     <= '0;
            cnt       <= '0;
            product_r <= '0;
        end else if (accept) begin
            m_ext <= m_load;
            acc   <= {{(WIDTH + 2){1'b0}}, a_load, 1'b0};
            cnt   <= '0;
        end else if (state == CALC) begin
            acc <= acc_step;
            cnt <= cnt + 1'b1;
            if (finish) product_r <= acc_step[2*WIDTH:1];
        end
    end

endmodule

// File: tb/tb_booth_radix4_seq.sv
// Self-checking bench for booth_radix4_seq: WIDTH=8 and WIDTH=4 instances,
// directed cases plus randomized operands against an arithmetic reference.
module tb_booth_radix4_seq;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

`ifdef BOOTH_UNSIGNED_EN
    localparam int N8 = 5;
    localparam int N4 = 3;
`else
    localparam int N8 = 4;
    localparam int N4 = 2;
`endif

    booth_radix4_seq_if #(.WIDTH(8)) if8 ();
    booth_radix4_seq_if #(.WIDTH(4)) if4 ();
    logic [1:0] dbg8;
    logic [1:0] dbg4;

    booth_radix4_seq #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (if8.slave),
        .dbg_state (dbg8)
    );

    booth_radix4_seq #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (if4.slave),
        .dbg_state (dbg4)
    );

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  exp4_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer multiplication of the (sign- or zero-) extended operands.
    function automatic logic [15:0] ref8(input logic [7:0] m, input logic [7:0] a, input logic sgn);
        longint mm, aa;
        mm = sgn ? longint'($signed(m)) : longint'(m);
        aa = sgn ? longint'($signed(a)) : longint'(a);
        return 16'(mm * aa);
    endfunction

    function automatic logic [7:0] ref4(input logic [3:0] m, input logic [3:0] a);
        longint mm, aa;
        mm = longint'($signed(m));
        aa = longint'($signed(a));
        return 8'(mm * aa);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic [7:0] m, input logic [7:0] a, input logic sgn,
                         input logic [15:0] exp);
        int guard = 0;
        while (!if8.in_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("w8 in_ready before accept", if8.in_ready, 1);
        if8.multiplicand = m;
        if8.multiplier   = a;
`ifdef BOOTH_UNSIGNED_EN
        if8.op_signed    = sgn;
`endif
        if8.in_valid     = 1'b1;
        tick();
        if8.in_valid     = 1'b0;
        // Operands must have been captured: scramble the inputs now.
        if8.multiplicand = 8'($urandom);
        if8.multiplier   = 8'($urandom);
`ifdef BOOTH_UNSIGNED_EN
        if8.op_signed    = ~sgn;
`endif
        exp_q.push_back(exp);
        check("w8 in_ready low after accept", if8.in_ready, 0);
    endtask

    task automatic recv8(input string tag, input int hold);
        int lat = 0;
        logic [15:0] exp;
        while (!if8.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, lat, N8);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        check({tag, " product"}, if8.product, exp);
        for (int i = 0; i < hold; i++) begin
            if8.out_ready    = 1'b0;
            if8.in_valid     = 1'b1;
            if8.multiplicand = 8'($urandom);
            if8.multiplier   = 8'($urandom);
            tick();
            check({tag, " held product"}, if8.product, exp);
            check({tag, " held out_valid"}, if8.out_valid, 1);
            check({tag, " in_ready under backpressure"}, if8.in_ready, 0);
        end
        if8.out_ready = 1'b1;
        tick();
        if8.out_ready = 1'b0;
        if8.in_valid  = 1'b0;
        check({tag, " out_valid dropped"}, if8.out_valid, 0);
        check({tag, " in_ready after drain"}, if8.in_ready, 1);
    endtask

    task automatic op4(input logic [3:0] m, input logic [3:0] a, input int hold);
        int lat = 0;
        logic [7:0] exp;
        if4.multiplicand = m;
        if4.multiplier   = a;
`ifdef BOOTH_UNSIGNED_EN
        if4.op_signed    = 1'b1;
`endif
        if4.in_valid     = 1'b1;
        tick();
        if4.in_valid     = 1'b0;
        if4.multiplicand = 4'($urandom);
        if4.multiplier   = 4'($urandom);
        exp4_q.push_back(ref4(m, a));
        while (!if4.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("w4 latency", lat, N4);
        exp = exp4_q.pop_front();
        for (int i = 0; i < hold; i++) tick();
        check("w4 product", if4.product, exp);
        if4.out_ready = 1'b1;
        tick();
        if4.out_ready = 1'b0;
        check("w4 in_ready after drain", if4.in_ready, 1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int order[256];
        logic [7:0] rm, ra;
        logic       rs;

        if8.in_valid = 1'b0; if8.out_ready = 1'b0;
        if8.multiplicand = '0; if8.multiplier = '0;
        if4.in_valid = 1'b0; if4.out_ready = 1'b0;
        if4.multiplicand = '0; if4.multiplier = '0;
`ifdef BOOTH_UNSIGNED_EN
        if8.op_signed = 1'b1;
        if4.op_signed = 1'b1;
`endif

        // Reset state.
        #12;
        check("reset w8 in_ready", if8.in_ready, 1);
        check("reset w8 out_valid", if8.out_valid, 0);
        check("reset w8 product", if8.product, 0);
        check("reset w4 in_ready", if4.in_ready, 1);
        check("reset w4 product", if4.product, 0);
        resetn = 1'b1;
        tick();

        // Signed directed cases.
        send8(8'd7, 8'hFD, 1'b1, 16'hFFEB);
        recv8("7*-3", 0);
        send8(8'h80, 8'h80, 1'b1, 16'h4000);
        recv8("-128*-128", 0);
        send8(8'h80, 8'h7F, 1'b1, 16'hC080);
        recv8("-128*127", 0);
`ifdef BOOTH_UNSIGNED_EN
        send8(8'hFF, 8'hFF, 1'b0, 16'hFE01);
        recv8("u255*255", 0);
        send8(8'hFF, 8'hFF, 1'b1, 16'h0001);
        recv8("s-1*-1", 0);
`endif

        // Back-pressure for 6 cycles with a competing in_valid.
        send8(8'h35, 8'hC2, 1'b1, ref8(8'h35, 8'hC2, 1'b1));
        recv8("backpressure", 6);
        tick();
        check("no second accept", if8.in_ready, 1);

        // Reset two cycles after accept aborts the operation.
        send8(8'h55, 8'h66, 1'b1, ref8(8'h55, 8'h66, 1'b1));
        tick();
        #2 resetn = 1'b0;
        #1;
        check("abort out_valid", if8.out_valid, 0);
        check("abort product", if8.product, 0);
        check("abort in_ready", if8.in_ready, 1);
        void'(exp_q.pop_front());
        #2 resetn = 1'b1;
        tick();
        send8(8'd3, 8'd5, 1'b1, 16'h000F);
        recv8("3*5 after abort", 0);

        // Randomized WIDTH=8 operations.
        for (int k = 0; k < 24; k++) begin
            rm = 8'($urandom);
            ra = 8'($urandom);
`ifdef BOOTH_UNSIGNED_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b1;
`endif
            send8(rm, ra, rs, ref8(rm, ra, rs));
            recv8("w8 random", $urandom_range(0, 2));
        end

        // WIDTH=4: corner, then all 256 signed pairs in shuffled order.
        op4(4'h8, 4'h8, 0);
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            int j, t;
            j = $urandom_range(0, i);
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        for (int i = 0; i < 256; i++) begin
            logic [7:0] pair;
            pair = 8'(order[i]);
            op4(pair[7:4], pair[3:0], $urandom_range(0, 1));
        end

        check("scoreboard drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
